// File: rtl/mul_div_unit_pkg.sv
// Shared CPU package: ALUOp and MDOp encodings, multiply/divide latencies,
// the multiply/divide FSM state type and small opcode helpers.
package mul_div_unit_pkg;

   // ALU operation encodings used by the main datapath.
   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_NOR  = 4'd5,
      ALU_SLT  = 4'd6,
      ALU_SLTU = 4'd7,
      ALU_SLL  = 4'd8,
      ALU_SRL  = 4'd9,
      ALU_SRA  = 4'd10,
      ALU_LUI  = 4'd11
   } aluop_t;

   // Multiply/divide unit operation encodings (111 is reserved, acts as NOP).
   typedef enum logic [2:0] {
      MD_NOP   = 3'b000,
      MD_MULT  = 3'b001,
      MD_MULTU = 3'b010,
      MD_DIV   = 3'b011,
      MD_DIVU  = 3'b100,
      MD_MTHI  = 3'b101,
      MD_MTLO  = 3'b110,
      MD_RSVD  = 3'b111
   } mdop_t;

   localparam int unsigned MULT_LAT = 5;
   localparam int unsigned DIV_LAT  = 10;
   localparam int unsigned CNT_W    = 4;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } mdu_state_t;

   // Operations that occupy the unit for several cycles.
   function automatic logic is_long_op(input mdop_t op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   // Counter load value: the counter runs from latency-1 down to 0, one Busy
   // cycle per count value.
   function automatic logic [CNT_W-1:0] first_count(input mdop_t op);
      if ((op == MD_DIV) || (op == MD_DIVU))
         return CNT_W'(DIV_LAT - 1);
      return CNT_W'(MULT_LAT - 1);
   endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational multiply/divide arithmetic.
// Ports:
//   a, b        : latched operands
//   op          : latched operation code
//   hi, lo      : 64-bit result {hi,lo}; product for MULT/MULTU,
//                 {remainder, quotient} for DIV/DIVU, zero otherwise
//   div_by_zero : division with b == 0 (result must not be written)
module mdu_calc
   import mul_div_unit_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  mdop_t       op,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        div_by_zero
);

   logic signed [63:0] prod_s;
   logic        [63:0] prod_u;
   logic               is_div;
   logic               neg_a;
   logic               neg_b;
   logic        [31:0] mag_a;
   logic        [31:0] mag_b;
   logic        [31:0] divisor;
   logic        [31:0] quo;
   logic        [31:0] rem;

   // Signed division is done on magnitudes so that 0x80000000 / -1 stays
   // well defined (its magnitude fits in 32 unsigned bits) and the result
   // truncates toward zero with the remainder following the dividend.
   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      prod_s      = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      prod_u      = {32'd0, a} * {32'd0, b};
      is_div      = (op == MD_DIV) || (op == MD_DIVU);
      neg_a       = (op == MD_DIV) && a[31];
      neg_b       = (op == MD_DIV) && b[31];
      mag_a       = neg_a ? (32'd0 - a) : a;
      mag_b       = neg_b ? (32'd0 - b) : b;
      div_by_zero = is_div && (b == 32'd0);
      // Substitute divisor 1 on zero so the divider never sees x/0.
      divisor     = (b == 32'd0) ? 32'd1 : mag_b;
      quo         = mag_a / divisor;
      rem         = mag_a % divisor;
      if (neg_a ^ neg_b)
         quo = 32'd0 - quo;
      if (neg_a)
         rem = 32'd0 - rem;

      case (op)
         MD_MULT:          {hi, lo} = prod_s;
         MD_MULTU:         {hi, lo} = prod_u;
         MD_DIV, MD_DIVU:  {hi, lo} = {rem, quo};
         default:          {hi, lo} = 64'd0;
      endcase
   end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous, active-low
//   A, B   : operands (rs, rt), sampled on an accepted Start
//   MDOp   : operation code, qualified by Start
//   Start  : one-cycle request strobe, ignored while Busy
//   Busy   : long operation (MULT/MULTU 5 cycles, DIV/DIVU 10 cycles) in flight
//   HI, LO : architectural HI/LO registers
module mul_div_unit
   import mul_div_unit_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [2:0]  MDOp,
   input  logic        Start,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   mdu_state_t       state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             accept;
   logic             load;
   logic             finish;
   mdop_t            op_in;

   logic [31:0]      a_q, b_q;
   mdop_t            op_q;
   logic [31:0]      res_hi, res_lo;
   logic             div_by_zero;

   assign op_in  = mdop_t'(MDOp);
   assign Busy   = (state == S_RUN);
   assign accept = Start && (state == S_IDLE);

   mdu_calc u_calc (
      .a           (a_q),
      .b           (b_q),
      .op          (op_q),
      .hi          (res_hi),
      .lo          (res_lo),
      .div_by_zero (div_by_zero)
   );

   // Next-state logic. The counter is loaded with latency-1 on acceptance,
   // so Busy covers exactly the latency and the last Busy cycle has cnt == 0.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      load    = 1'b0;
      finish  = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept && is_long_op(op_in)) begin
               state_n = S_RUN;
               cnt_n   = first_count(op_in);
               load    = 1'b1;
            end
         end
         S_RUN: begin
            if (cnt == '0) begin
               state_n = S_IDLE;
               finish  = 1'b1;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         default: begin
            state_n = S_IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!reset) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // Operand latches, HI/LO. Reset wins over Start and cancels any pending
   // result write because finish is never acted on while reset is low.
   always_ff @(posedge clk) begin
      if (!reset) begin
         a_q  <= '0;
         b_q  <= '0;
         op_q <= MD_NOP;
         HI   <= '0;
         LO   <= '0;
      end else begin
         if (load) begin
            a_q  <= A;
            b_q  <= B;
            op_q <= op_in;
         end
         if (finish) begin
            if (!div_by_zero) begin
               HI <= res_hi;
               LO <= res_lo;
            end
         end else if (accept) begin
            if (op_in == MD_MTHI)
               HI <= A;
            if (op_in == MD_MTLO)
               LO <= A;
         end
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit.
module tb_mul_div_unit;
   import mul_div_unit_pkg::*;

   logic        clk;
   logic        reset;
   logic [31:0] A, B;
   logic [2:0]  MDOp;
   logic        Start;
   logic        Busy;
   logic [31:0] HI, LO;

   int errors = 0;
   int checks = 0;

   mul_div_unit dut (
      .clk   (clk),
      .reset (reset),
      .A     (A),
      .B     (B),
      .MDOp  (MDOp),
      .Start (Start),
      .Busy  (Busy),
      .HI    (HI),
      .LO    (LO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one cycle; outputs are observed 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Present a request for one cycle; afterwards the simulation sits in the
   // cycle following the sampling edge.
   task automatic issue(input mdop_t op, input logic [31:0] a, input logic [31:0] b);
      MDOp  = op;
      A     = a;
      B     = b;
      Start = 1'b1;
      tick();
      Start = 1'b0;
      MDOp  = MD_NOP;
   endtask

   // Called in busy cycle 1: expects n Busy cycles with HI/LO held, scrambling
   // the operand inputs meanwhile, then expects Busy low.
   task automatic expect_busy(input string tag, input int n,
                              input logic [31:0] hold_hi, input logic [31:0] hold_lo);
      for (int i = 0; i < n; i++) begin
         check({tag, " busy"}, {31'd0, Busy}, 32'd1);
         check({tag, " hold_hi"}, HI, hold_hi);
         check({tag, " hold_lo"}, LO, hold_lo);
         A = $urandom;
         B = $urandom;
         tick();
      end
      check({tag, " done"}, {31'd0, Busy}, 32'd0);
   endtask

   initial begin
      reset = 1'b0;
      Start = 1'b0;
      MDOp  = MD_NOP;
      A     = '0;
      B     = '0;
      tick();
      tick();
      reset = 1'b1;
      check("reset busy", {31'd0, Busy}, 32'd0);
      check("reset hi", HI, 32'd0);
      check("reset lo", LO, 32'd0);

      // MULT -2 * 3 = -6
      issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
      expect_busy("mult", 5, 32'd0, 32'd0);
      check("mult hi", HI, 32'hFFFF_FFFF);
      check("mult lo", LO, 32'hFFFF_FFFA);

      // Back-to-back MULTU 0xFFFFFFFF^2 = 0xFFFFFFFE_00000001
      issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      expect_busy("multu", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      check("multu hi", HI, 32'hFFFF_FFFE);
      check("multu lo", LO, 32'h0000_0001);

      // DIV -7 / 2: quotient -3, remainder -1
      issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
      expect_busy("div", 10, 32'hFFFF_FFFE, 32'h0000_0001);
      check("div lo", LO, 32'hFFFF_FFFD);
      check("div hi", HI, 32'hFFFF_FFFF);

      // MTHI / MTLO: no Busy, visible next cycle
      issue(MD_MTHI, 32'h11, 32'd0);
      check("mthi busy", {31'd0, Busy}, 32'd0);
      check("mthi hi", HI, 32'h11);
      issue(MD_MTLO, 32'h22, 32'd0);
      check("mtlo busy", {31'd0, Busy}, 32'd0);
      check("mtlo lo", LO, 32'h22);

      // Reserved opcode acts as NOP
      issue(MD_RSVD, 32'h33, 32'h44);
      check("rsvd busy", {31'd0, Busy}, 32'd0);
      check("rsvd hi", HI, 32'h11);
      check("rsvd lo", LO, 32'h22);

      // DIVU 100 / 0: full latency, HI/LO untouched
      issue(MD_DIVU, 32'd100, 32'd0);
      expect_busy("divu0", 10, 32'h11, 32'h22);
      check("divu0 hi", HI, 32'h11);
      check("divu0 lo", LO, 32'h22);

      // MULT 3*4 with an ignored DIVU 9/2 request at busy cycle 2
      issue(MD_MULT, 32'd3, 32'd4);
      check("ign c1 busy", {31'd0, Busy}, 32'd1);
      tick();
      MDOp  = MD_DIVU;
      A     = 32'd9;
      B     = 32'd2;
      Start = 1'b1;
      check("ign c2 busy", {31'd0, Busy}, 32'd1);
      tick();
      Start = 1'b0;
      MDOp  = MD_NOP;
      expect_busy("ign", 3, 32'h11, 32'h22);
      check("ign hi", HI, 32'd0);
      check("ign lo", LO, 32'd12);
      issue(MD_MTLO, 32'h55, 32'd0);
      check("ign mtlo lo", LO, 32'h55);
      check("ign mtlo hi", HI, 32'd0);
      check("ign no divu", {31'd0, Busy}, 32'd0);
      tick();
      check("ign still idle", {31'd0, Busy}, 32'd0);

      // DIV overflow case 0x80000000 / -1
      issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      expect_busy("divovf", 10, 32'd0, 32'h55);
      check("divovf lo", LO, 32'h8000_0000);
      check("divovf hi", HI, 32'd0);

      // DIVU 100 / 7 = 14 r 2
      issue(MD_DIVU, 32'd100, 32'd7);
      expect_busy("divu", 10, 32'd0, 32'h8000_0000);
      check("divu lo", LO, 32'd14);
      check("divu hi", HI, 32'd2);

      // Reset at busy cycle 7 of a DIV 100 / 7
      issue(MD_DIV, 32'd100, 32'd7);
      for (int i = 0; i < 6; i++) tick();
      check("rst c7 busy", {31'd0, Busy}, 32'd1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("rst busy", {31'd0, Busy}, 32'd0);
      check("rst hi", HI, 32'd0);
      check("rst lo", LO, 32'd0);
      // Start accepted in the first cycle after reset; the aborted DIV must
      // not land in HI/LO during or after it.
      issue(MD_MULTU, 32'd2, 32'd3);
      expect_busy("postrst", 5, 32'd0, 32'd0);
      check("postrst hi", HI, 32'd0);
      check("postrst lo", LO, 32'd6);
      for (int i = 0; i < 6; i++) tick();
      check("postrst late hi", HI, 32'd0);
      check("postrst late lo", LO, 32'd6);

      // Reset has priority over Start
      issue(MD_MTHI, 32'h77, 32'd0);
      check("pri mthi", HI, 32'h77);
      reset = 1'b0;
      issue(MD_MTHI, 32'h99, 32'd0);
      reset = 1'b1;
      check("pri hi", HI, 32'd0);
      check("pri lo", LO, 32'd0);
      check("pri busy", {31'd0, Busy}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
